// File: rtl/fp32_pkg.sv
// fp32_pkg: shared FP32 field widths, constants and operand classification
// used by the multiplier datapath.
package fp32_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int          BIAS  = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // Denormals (exp=0, mant!=0) classify as zero: the datapath flushes them.
    function automatic fp_class_e classify(input logic [31:0] x);
        fp_class_e c;
        if (x[30:23] == EXP_MAX) begin
            c = (x[22:0] != '0) ? FP_NAN : FP_INF;
        end else if (x[30:23] == '0) begin
            c = FP_ZERO;
        end else begin
            c = FP_NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp32_mant_mul.sv
// fp32_mant_mul: 24x24 unsigned mantissa multiplier with an enabled output
// register (stage 2 of fp32_mul_pipe).
module fp32_mant_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic [47:0] p
);

    logic [47:0] p_d;
    logic [47:0] p_q;

    // Full-width product of the two hidden-bit mantissas.
    always_comb begin
        p_d = {24'b0, a} * {24'b0, b};
    end

    // Product register; holds while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q <= '0;
        end else if (en) begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/fp32_mul_pipe.sv
// fp32_mul_pipe: 3-stage pipelined FP32 multiplier (C = A*B), flush-to-zero,
// valid/ready handshake, whole-pipeline freeze on output back-pressure.
// Config macro FP32_MUL_RNE_EN: defined -> round-to-nearest-even,
// undefined -> truncate.
module fp32_mul_pipe #(
    parameter int BIAS   = fp32_pkg::BIAS,
    parameter int STAGES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] C
);
    import fp32_pkg::*;

    generate
        if (STAGES != 3) begin : g_bad_stages
            $error("fp32_mul_pipe: STAGES must be 3");
        end
    endgenerate

`ifdef FP32_MUL_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif

    logic adv;

    fp_class_e   cls_a, cls_b;
    logic        v1_d, v1_q, s1_d, s1_q, sp1_d, sp1_q;
    logic [31:0] spv1_d, spv1_q;
    logic [9:0]  e1_d, e1_q;
    logic [23:0] ma1_d, ma1_q, mb1_d, mb1_q;

    logic        v2_d, v2_q, s2_d, s2_q, sp2_d, sp2_q;
    logic [31:0] spv2_d, spv2_q;
    logic [9:0]  e2_d, e2_q;
    logic [47:0] p_w;

    logic [22:0]        mant, man_f;
    logic               guard, sticky, inc;
    logic [23:0]        mant_r;
    logic signed [9:0]  e_n, e_f;
    logic [31:0]        res;
    logic               ov_d, ov_q;
    logic [31:0]        c_d, c_q;

    assign adv       = ~(ov_q & ~out_ready);
    assign in_ready  = adv;
    assign out_valid = ov_q;
    assign C         = c_q;

    // Stage 1: sign, classification/special result, biased exponent sum.
    always_comb begin
        cls_a  = classify(A);
        cls_b  = classify(B);
        v1_d   = in_valid;
        s1_d   = A[31] ^ B[31];
        sp1_d  = 1'b1;
        spv1_d = '0;
        if (cls_a == FP_NAN || cls_b == FP_NAN ||
            (cls_a == FP_INF && cls_b == FP_ZERO) ||
            (cls_a == FP_ZERO && cls_b == FP_INF)) begin
            spv1_d = QNAN;
        end else if (cls_a == FP_INF || cls_b == FP_INF) begin
            spv1_d = {s1_d, EXP_MAX, {MAN_W{1'b0}}};
        end else if (cls_a == FP_ZERO || cls_b == FP_ZERO) begin
            spv1_d = {s1_d, 31'b0};
        end else begin
            sp1_d = 1'b0;
        end
        e1_d  = {2'b00, A[30:23]} + {2'b00, B[30:23]} - 10'(BIAS);
        ma1_d = {1'b1, A[22:0]};
        mb1_d = {1'b1, B[22:0]};
    end

    // Stage 2 side-band: carry sign/special/exponent alongside the product.
    always_comb begin
        v2_d   = v1_q;
        s2_d   = s1_q;
        sp2_d  = sp1_q;
        spv2_d = spv1_q;
        e2_d   = e1_q;
    end

    // Stage 1 and stage 2 side-band registers; frozen during a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0; s1_q <= 1'b0; sp1_q <= 1'b0; spv1_q <= '0;
            e1_q <= '0;   ma1_q <= '0;  mb1_q <= '0;
            v2_q <= 1'b0; s2_q <= 1'b0; sp2_q <= 1'b0; spv2_q <= '0;
            e2_q <= '0;
        end else if (adv) begin
            v1_q <= v1_d; s1_q <= s1_d; sp1_q <= sp1_d; spv1_q <= spv1_d;
            e1_q <= e1_d; ma1_q <= ma1_d; mb1_q <= mb1_d;
            v2_q <= v2_d; s2_q <= s2_d; sp2_q <= sp2_d; spv2_q <= spv2_d;
            e2_q <= e2_d;
        end
    end

    fp32_mant_mul u_mant_mul (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .a   (ma1_q),
        .b   (mb1_q),
        .p   (p_w)
    );

    // Stage 3: normalise, round, range-check and pack.
    always_comb begin
        if (p_w[47]) begin
            mant   = p_w[46:24];
            guard  = p_w[23];
            sticky = |p_w[22:0];
            e_n    = $signed(e2_q) + 10'sd1;
        end else begin
            mant   = p_w[45:23];
            guard  = p_w[22];
            sticky = |p_w[21:0];
            e_n    = $signed(e2_q);
        end
        inc    = RNE & guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {23'b0, inc};
        if (mant_r[23]) begin
            man_f = '0;
            e_f   = e_n + 10'sd1;
        end else begin
            man_f = mant_r[22:0];
            e_f   = e_n;
        end
        if (sp2_q) begin
            res = spv2_q;
        end else if (e_f >= 10'sd255) begin
            res = {s2_q, EXP_MAX, 23'b0};
        end else if (e_f <= 10'sd0) begin
            res = {s2_q, 31'b0};
        end else begin
            res = {s2_q, e_f[7:0], man_f};
        end
        ov_d = v2_q;
        c_d  = v2_q ? res : c_q;
    end

    // Output register; holds the presented result until it is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ov_q <= 1'b0;
            c_q  <= '0;
        end else if (adv) begin
            ov_q <= ov_d;
            c_q  <= c_d;
        end
    end

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// tb_fp32_mul_pipe: directed-vector bench for fp32_mul_pipe with an in-order
// expected-result queue; rounding-tie expectation follows FP32_MUL_RNE_EN.
module tb_fp32_mul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] C;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned n_out = 0;
    logic [31:0] exp_in = '0;
    logic [31:0] exp_q[$];

`ifdef FP32_MUL_RNE_EN
    localparam logic [31:0] TIE_EXP = 32'h3FC0_0002;
`else
    localparam logic [31:0] TIE_EXP = 32'h3FC0_0001;
`endif

    always #5 clk = ~clk;

    fp32_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Scoreboard: record accepted inputs, check every accepted output in order.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    check("C_seq", C, exp_q.pop_front());
                end
                n_out++;
            end
            if (in_valid && in_ready) exp_q.push_back(exp_in);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        bit          acc;
        int unsigned n;
        n        = 0;
        A        = a;
        B        = b;
        exp_in   = e;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) check("issue_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic lat_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e);
        issue(a, b, e);
        idle();
        check({tag, "_v1"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_v2"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_v3"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_C"}, C, e);
        drain({tag, "_drain"});
    endtask

    logic [31:0] va[11];
    logic [31:0] vb[11];
    logic [31:0] ve[11];
    logic [31:0] sa[6];
    logic [31:0] sb[6];
    logic [31:0] se[6];
    int unsigned n0;

    initial begin
        va = '{32'h3FC00000, 32'h7F800000, 32'hFF800000, 32'h00000001, 32'h7F000000,
               32'h00800000, 32'h3F800001, 32'h7FC00000, 32'h80000000, 32'hFF800000,
               32'hFF800000};
        vb = '{32'h3FC00000, 32'h00000000, 32'h40000000, 32'h40000000, 32'h7F000000,
               32'h00800000, 32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'hFF800000,
               32'h80000000};
        ve = '{32'h40100000, 32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h7F800000,
               32'h00000000, TIE_EXP,      32'h7FC00000, 32'h80000000, 32'h7F800000,
               32'h7FC00000};
        sa = '{32'h40000000, 32'h3FC00000, 32'h40000000, 32'h3F800000, 32'h40400000,
               32'hC0000000};
        sb = '{32'h40400000, 32'h3FC00000, 32'h40000000, 32'h3F800000, 32'h40400000,
               32'h40400000};
        se = '{32'h40C00000, 32'h40100000, 32'h40800000, 32'h3F800000, 32'h41100000,
               32'hC0C00000};

        // Reset state.
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_C", C, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Single op with exact latency.
        lat_op("mul_2x3", 32'h40000000, 32'h40400000, 32'h40C00000);

        // Directed vectors: normalise, specials, range limits, rounding tie.
        for (int i = 0; i < 11; i++) begin
            issue(va[i], vb[i], ve[i]);
            idle();
            drain("vec_drain");
        end

        // Back-pressure: 6 back-to-back ops, output stalled 5 cycles mid-stream.
        n0 = n_out;
        fork
            begin : bp_src
                for (int i = 0; i < 6; i++) issue(sa[i], sb[i], se[i]);
                idle();
            end
            begin : bp_sink
                int unsigned n;
                n = 0;
                while (!out_valid && n < 20) begin
                    @(posedge clk); #1;
                    n++;
                end
                check("bp_first_out", {31'b0, out_valid}, 32'd1);
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
                    check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_count", n_out - n0, 32'd6);

        // Reset with three ops in flight.
        issue(32'h40000000, 32'h40000000, 32'h40800000);
        issue(32'h40400000, 32'h40400000, 32'h41100000);
        issue(32'h3FC00000, 32'h3FC00000, 32'h40100000);
        idle();
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_C", C, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", {31'b0, out_valid}, 32'd0);
        lat_op("post_rst", 32'h3F800000, 32'h40000000, 32'h40000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
